pc_alu_unit: RTL and testbench

- Execute/fetch arithmetic slice of the single-cycle RV32I datapath.
- Contains:
  - the program-counter register (async-reset flop);
  - two PC adders: pc+4 and pc+imm;
  - the 32-bit integer ALU with a zero flag.
- Surrounding logic (muxes, regfile, immediate decode) selects pcnext and ALU operands externally.

---
 rtl/pc_alu_unit.sv | 82 ++++++++
 tb/tb_pc_alu_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_alu_unit.sv
// Execute/fetch arithmetic slice of the single-cycle RV32I datapath.
// Contains the PC register, the pc+4 and pc+imm adders, and the integer ALU with its zero flag.
module pc_alu_unit #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcnext,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluctr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcplus4,
  output logic [WIDTH-1:0] pcbranch,
  output logic [WIDTH-1:0] aluout,
  output logic             iszero
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_e;

  logic [WIDTH-1:0] r_pc;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_lt_signed;
  logic             w_lt_unsigned;

  // Every edge loads pcnext; stall/flush muxing lives outside this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= pcnext;
    end
  end

  assign pc       = r_pc;
  assign pcplus4  = r_pc + WIDTH'(4);
  assign pcbranch = r_pc + imm;

  assign w_shamt       = b[SHW-1:0];
  assign w_lt_signed   = $signed(a) < $signed(b);
  assign w_lt_unsigned = a < b;

  always_comb begin
    w_result = '0;
    case (aluctr)
      ALU_ADD:   w_result = a + b;
      ALU_SUB:   w_result = a - b;
      ALU_SLL:   w_result = a << w_shamt;
      ALU_SLT:   w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
      ALU_SLTU:  w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
      ALU_XOR:   w_result = a ^ b;
      ALU_SRL:   w_result = a >> w_shamt;
      ALU_SRA:   w_result = $unsigned($signed(a) >>> w_shamt);
      ALU_OR:    w_result = a | b;
      ALU_AND:   w_result = a & b;
      ALU_PASSB: w_result = b;
      default:   w_result = '0;
    endcase
  end

  // Zero flag follows the final result, so undefined codes report zero.
  assign aluout = w_result;
  assign iszero = (w_result == '0);

endmodule

// File: tb/tb_pc_alu_unit.sv
// Directed self-checking bench for pc_alu_unit: async PC reset, PC adders, and every ALU operation.
module tb_pc_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pcnext;
  logic [31:0] imm;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluctr;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] aluout;
  logic        iszero;

  int nCompared   = 0;
  int nMismatched = 0;

  pc_alu_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pcnext  (pcnext),
    .imm     (imm),
    .a       (a),
    .b       (b),
    .aluctr  (aluctr),
    .pc      (pc),
    .pcplus4 (pcplus4),
    .pcbranch(pcbranch),
    .aluout  (aluout),
    .iszero  (iszero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives ALU operands between clock edges and lets the combinational result settle.
  task automatic applyStimulus(input logic [3:0] ctr, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    aluctr = ctr;
    a      = va;
    b      = vb;
    #1;
  endtask

  task automatic checkAlu(input string tag, input logic [31:0] expOut, input logic expZero);
    checkOutput({tag, ".aluout"}, aluout, expOut);
    checkOutput({tag, ".iszero"}, {31'b0, iszero}, {31'b0, expZero});
  endtask

  initial begin
    reset  = 1'b1;
    pcnext = 32'h0000_0040;
    imm    = 32'h0;
    a      = 32'h0;
    b      = 32'h0;
    aluctr = 4'b0000;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_pc", pc, 32'h0000_0000);

    // Release reset, load 0x40
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("load_0x40", pc, 32'h0000_0040);

    // Async reset between edges
    pcnext = 32'h0000_1234;
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", pc, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", pc, 32'h0000_0000);

    // Deassert mid-cycle; pc changes only at the next edge
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("deassert_no_edge", pc, 32'h0000_0000);
    @(posedge clk); #1;
    checkOutput("deassert_edge", pc, 32'h0000_1234);

    // PC adders
    pcnext = 32'h0000_0100;
    imm    = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    checkOutput("pc_0x100", pc, 32'h0000_0100);
    checkOutput("pcplus4_0x104", pcplus4, 32'h0000_0104);
    checkOutput("pcbranch_0xF8", pcbranch, 32'h0000_00F8);

    pcnext = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    checkOutput("pcplus4_wrap", pcplus4, 32'h0000_0000);
    checkOutput("pcbranch_wrap", pcbranch, 32'hFFFF_FFF4);

    // Arithmetic
    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    checkAlu("add_ovf", 32'h8000_0000, 1'b0);
    applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    checkAlu("add_wrap", 32'h0000_0000, 1'b1);
    applyStimulus(4'b1000, 32'h0000_0005, 32'h0000_0005);
    checkAlu("sub_zero", 32'h0000_0000, 1'b1);
    applyStimulus(4'b1000, 32'h0000_0000, 32'h0000_0001);
    checkAlu("sub_neg", 32'hFFFF_FFFF, 1'b0);

    // Compares
    applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    checkAlu("slt_neg", 32'h0000_0001, 1'b0);
    applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
    checkAlu("sltu_big", 32'h0000_0000, 1'b1);
    applyStimulus(4'b0010, 32'h0000_0007, 32'h0000_0007);
    checkAlu("slt_eq", 32'h0000_0000, 1'b1);
    applyStimulus(4'b0011, 32'h0000_0001, 32'hFFFF_FFFF);
    checkAlu("sltu_small", 32'h0000_0001, 1'b0);

    // Shifts, b[31:5] must be ignored
    applyStimulus(4'b0001, 32'h8000_00F0, 32'h0000_0024);
    checkAlu("sll_4", 32'h0000_0F00, 1'b0);
    applyStimulus(4'b0101, 32'h8000_00F0, 32'h0000_0024);
    checkAlu("srl_4", 32'h0800_000F, 1'b0);
    applyStimulus(4'b1101, 32'h8000_00F0, 32'h0000_0024);
    checkAlu("sra_4", 32'hF800_000F, 1'b0);
    applyStimulus(4'b1101, 32'h4000_00F0, 32'h0000_0024);
    checkAlu("sra_pos", 32'h0400_000F, 1'b0);
    applyStimulus(4'b0001, 32'h8000_00F0, 32'hFFFF_FFE0);
    checkAlu("sll_0", 32'h8000_00F0, 1'b0);
    applyStimulus(4'b1101, 32'h8000_00F0, 32'h0000_0020);
    checkAlu("sra_0", 32'h8000_00F0, 1'b0);
    applyStimulus(4'b0101, 32'h8000_0000, 32'h0000_001F);
    checkAlu("srl_31", 32'h0000_0001, 1'b0);

    // Logic and pass
    applyStimulus(4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checkAlu("and", 32'h00F0_00F0, 1'b0);
    applyStimulus(4'b0110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checkAlu("or", 32'hFFF0_FFF0, 1'b0);
    applyStimulus(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    checkAlu("xor", 32'hFF00_FF00, 1'b0);
    applyStimulus(4'b1001, 32'hDEAD_BEEF, 32'h1234_5000);
    checkAlu("passb", 32'h1234_5000, 1'b0);

    // Undefined codes
    applyStimulus(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkAlu("undef_1111", 32'h0000_0000, 1'b1);
    applyStimulus(4'b1010, 32'h0000_0003, 32'h0000_0004);
    checkAlu("undef_1010", 32'h0000_0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
